// File: rtl/shift_seq8_pkg.sv
// rtl/shift_seq8_pkg.sv - opcode and FSM state encodings shared with the shifter next-state logic
package shift_seq8_pkg;

    localparam int DATA_W = 8;
    localparam logic [1:0] MAX_STEP = 2'd3;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LOAD = 3'd1,
        OP_LSL  = 3'd2,
        OP_LSR  = 3'd3,
        OP_ASR  = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic is_shift(input logic [2:0] code);
        return (code == OP_LSL) || (code == OP_LSR) || (code == OP_ASR);
    endfunction

    function automatic logic is_illegal(input logic [2:0] code);
        return code > OP_ASR;
    endfunction

endpackage

// File: rtl/shift_seq8_step_sel.sv
// rtl/shift_seq8_step_sel.sv - per-cycle step size, min(remaining, 3)
module step_sel
    import shift_seq8_pkg::*;
(
    input  logic [2:0] remaining,
    output logic [1:0] shamt
);

    assign shamt = (remaining >= 3'd3) ? MAX_STEP : remaining[1:0];

endmodule

// File: rtl/shift_seq8.sv
// rtl/shift_seq8.sv - command sequencer that drives a downstream 8-bit shifter in steps of up to 3
module shift_seq8
    import shift_seq8_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [2:0]          cmd_amt,
    input  logic [DATA_W-1:0]   cmd_data,
    input  logic [DATA_W-1:0]   sh_q,
    output logic [2:0]          op,
    output logic [1:0]          shamt,
    output logic [DATA_W-1:0]   d_in,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [DATA_W-1:0]   result
);

    state_e              state;
    state_e              state_nxt;
    logic [2:0]          remaining;
    logic [2:0]          lat_op;
    logic [DATA_W-1:0]   lat_data;
    logic [1:0]          step;
    logic                accept;

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid & cmd_ready;

    step_sel u_step_sel (
        .remaining (remaining),
        .shamt     (step)
    );

    // remaining doubles as the latched shift amount; it only counts down in SHIFT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            remaining <= 3'd0;
            lat_op    <= 3'd0;
            lat_data  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_op    <= cmd_op;
                lat_data  <= cmd_data;
                remaining <= is_shift(cmd_op) ? cmd_amt : 3'd0;
            end else if (state == ST_SHIFT) begin
                remaining <= remaining - {1'b0, step};
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_LOAD)
                        state_nxt = ST_LOAD;
                    else if (is_shift(cmd_op) && (cmd_amt != 3'd0))
                        state_nxt = ST_SHIFT;
                    else
                        state_nxt = ST_DONE;
                end
            end
            ST_LOAD:  state_nxt = ST_DONE;
            ST_SHIFT: begin
                if ({1'b0, step} == remaining)
                    state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        op    = OP_NOP;
        shamt = 2'd0;
        d_in  = '0;
        case (state)
            ST_LOAD: begin
                op   = OP_LOAD;
                d_in = lat_data;
            end
            ST_SHIFT: begin
                op    = lat_op;
                shamt = step;
                d_in  = sh_q;
            end
            default: ;
        endcase
    end

    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_DONE);
    assign err    = done && is_illegal(lat_op);
    assign result = done ? sh_q : '0;

endmodule

// File: tb/tb_shift_seq8.sv
// tb/tb_shift_seq8.sv - directed table-driven bench for shift_seq8 with a behavioural shifter register
module tb_shift_seq8;

    typedef struct {
        logic [2:0] op;
        logic [2:0] amt;
        logic [7:0] data;
        int         n_issue;
        logic [4:0] tr0;
        logic [4:0] tr1;
        logic [4:0] tr2;
        logic [7:0] res;
        logic       er;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [2:0] cmd_amt;
    logic [7:0] cmd_data;
    logic [7:0] sh_q = 8'h00;
    logic [2:0] op;
    logic [1:0] shamt;
    logic [7:0] d_in;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] result;

    int total = 0;
    int bad   = 0;
    vec_t vecs[11];

    shift_seq8 dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_amt   (cmd_amt),
        .cmd_data  (cmd_data),
        .sh_q      (sh_q),
        .op        (op),
        .shamt     (shamt),
        .d_in      (d_in),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .result    (result)
    );

    always #5 clk = ~clk;

    // downstream shifter register
    always @(posedge clk) begin
        case (op)
            3'd1:    sh_q <= d_in;
            3'd2:    sh_q <= d_in << shamt;
            3'd3:    sh_q <= d_in >> shamt;
            3'd4:    sh_q <= $signed(d_in) >>> shamt;
            default: sh_q <= sh_q;
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] o, input logic [2:0] a, input logic [7:0] d,
                                input int n, input logic [4:0] t0, input logic [4:0] t1,
                                input logic [4:0] t2, input logic [7:0] r, input logic e);
        vec_t v;
        v.op = o; v.amt = a; v.data = d; v.n_issue = n;
        v.tr0 = t0; v.tr1 = t1; v.tr2 = t2; v.res = r; v.er = e;
        return v;
    endfunction

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_op"}, int'(op), 0);
        chk({nm, "_shamt"}, int'(shamt), 0);
        chk({nm, "_d_in"}, int'(d_in), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_err"}, int'(err), 0);
        chk({nm, "_result"}, int'(result), 0);
        chk({nm, "_ready"}, int'(cmd_ready), 1);
    endtask

    // entered and left at a negedge with the DUT idle
    task automatic run_vec(input vec_t v, input string nm);
        logic [4:0] exp_tr;
        logic [7:0] exp_d;
        bit got;
        chk({nm, "_ready_idle"}, int'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_op = v.op; cmd_amt = v.amt; cmd_data = v.data;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_amt = 3'd0; cmd_data = 8'h00;
        got = 1'b0;
        for (int k = 1; k <= 6 && !got; k++) begin
            if (done) begin
                chk({nm, "_done_cycle"}, k, v.n_issue + 1);
                chk({nm, "_result"}, int'(result), int'(v.res));
                chk({nm, "_err"}, int'(err), int'(v.er));
                chk({nm, "_done_op"}, int'({op, shamt}), 0);
                chk({nm, "_done_d_in"}, int'(d_in), 0);
                got = 1'b1;
            end else begin
                chk({nm, "_busy"}, int'(busy), 1);
                chk({nm, "_ready_busy"}, int'(cmd_ready), 0);
                chk({nm, "_err_early"}, int'(err), 0);
                exp_tr = (k == 1) ? v.tr0 : (k == 2) ? v.tr1 : (k == 3) ? v.tr2 : 5'd0;
                chk({nm, "_op_shamt"}, int'({op, shamt}), int'(exp_tr));
                exp_d = (exp_tr[4:2] == 3'd1) ? v.data : sh_q;
                chk({nm, "_d_in"}, int'(d_in), int'(exp_d));
                @(negedge clk);
            end
        end
        if (!got) chk({nm, "_timeout"}, 0, 1);
        @(negedge clk);
        chk({nm, "_idle_busy"}, int'(busy), 0);
        chk({nm, "_idle_done"}, int'(done), 0);
    endtask

    initial begin
        vecs[0]  = mk(3'd1, 3'd0, 8'hA5, 1, {3'd1, 2'd0}, 5'd0, 5'd0, 8'hA5, 1'b0);
        vecs[1]  = mk(3'd2, 3'd5, 8'h00, 2, {3'd2, 2'd3}, {3'd2, 2'd2}, 5'd0, 8'hA0, 1'b0);
        vecs[2]  = mk(3'd1, 3'd3, 8'h80, 1, {3'd1, 2'd0}, 5'd0, 5'd0, 8'h80, 1'b0);
        vecs[3]  = mk(3'd4, 3'd7, 8'h11, 3, {3'd4, 2'd3}, {3'd4, 2'd3}, {3'd4, 2'd1}, 8'hFF, 1'b0);
        vecs[4]  = mk(3'd1, 3'd0, 8'h3C, 1, {3'd1, 2'd0}, 5'd0, 5'd0, 8'h3C, 1'b0);
        vecs[5]  = mk(3'd3, 3'd0, 8'h00, 0, 5'd0, 5'd0, 5'd0, 8'h3C, 1'b0);
        vecs[6]  = mk(3'd7, 3'd5, 8'h12, 0, 5'd0, 5'd0, 5'd0, 8'h3C, 1'b1);
        vecs[7]  = mk(3'd0, 3'd6, 8'h99, 0, 5'd0, 5'd0, 5'd0, 8'h3C, 1'b0);
        vecs[8]  = mk(3'd3, 3'd3, 8'h00, 1, {3'd3, 2'd3}, 5'd0, 5'd0, 8'h07, 1'b0);
        vecs[9]  = mk(3'd5, 3'd2, 8'h00, 0, 5'd0, 5'd0, 5'd0, 8'h07, 1'b1);
        vecs[10] = mk(3'd2, 3'd4, 8'h00, 2, {3'd2, 2'd3}, {3'd2, 2'd1}, 5'd0, 8'h70, 1'b0);

        reset = 1'b1;
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_amt = 3'd0; cmd_data = 8'h00;
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // cmd_valid held high: second command must wait until the IDLE after done
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_amt = 3'd1; cmd_data = 8'h00;
        @(posedge clk);
        @(negedge clk);
        cmd_op = 3'd1; cmd_data = 8'h55;
        chk("b2b_c1_op", int'({op, shamt}), int'({3'd2, 2'd1}));
        chk("b2b_c1_ready", int'(cmd_ready), 0);
        @(negedge clk);
        chk("b2b_c2_done", int'(done), 1);
        chk("b2b_c2_result", int'(result), 8'hE0);
        chk("b2b_c2_ready", int'(cmd_ready), 0);
        @(negedge clk);
        chk("b2b_c3_ready", int'(cmd_ready), 1);
        chk("b2b_c3_busy", int'(busy), 0);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'h00;
        chk("b2b_c4_op", int'({op, shamt}), int'({3'd1, 2'd0}));
        chk("b2b_c4_d_in", int'(d_in), 8'h55);
        @(negedge clk);
        chk("b2b_c5_done", int'(done), 1);
        chk("b2b_c5_result", int'(result), 8'h55);
        @(negedge clk);

        // reset mid-command, during the second SHIFT cycle of LSL 7
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_amt = 3'd7;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_amt = 3'd0;
        chk("rst_c1_op", int'({op, shamt}), int'({3'd2, 2'd3}));
        @(negedge clk);
        chk("rst_c2_op", int'({op, shamt}), int'({3'd2, 2'd3}));
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rst_nodone%0d", k), int'(done), 0);
        end
        run_vec(mk(3'd1, 3'd0, 8'h5A, 1, {3'd1, 2'd0}, 5'd0, 5'd0, 8'h5A, 1'b0), "post_load");
        run_vec(mk(3'd3, 3'd2, 8'h00, 1, {3'd3, 2'd2}, 5'd0, 5'd0, 8'h16, 1'b0), "post_lsr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_seq8.md
SHIFT_SEQ8 -- requirements
Module: shift_seq8

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 8 bits.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock, shared with the downstream shifter register.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accepted on the edge where cmd_valid & cmd_ready.
REQ-007 cmd_op  input  3  command code: NOP 000, LOAD 001, LSL 010, LSR 011, ASR 100.
REQ-008 cmd_amt  input  3  total shift distance, 0..7; ignored for LOAD.
REQ-009 cmd_data  input  8  load value; ignored for shift commands.
REQ-010 sh_q  input  8  current shifter register contents (feedback).
REQ-011 op  output  3  per-cycle opcode to the shifter next-state logic.
REQ-012 shamt  output  2  per-cycle shift amount, 0..3.
REQ-013 d_in  output  8  per-cycle data operand to the shifter.
REQ-014 busy  output  1  high while a command is in progress (not IDLE).
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 err  output  1  one-cycle pulse coincident with done for an illegal cmd_op.
REQ-017 result  output  8  equals sh_q while done=1, otherwise 0.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, SHIFT and DONE, with the state held in registers.
REQ-019 cmd_ready SHALL be 1 only in IDLE; cmd_valid outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-020 On acceptance, the block SHALL latch cmd_op, cmd_amt and cmd_data into internal registers.
REQ-021 On acceptance, the next state SHALL be as follows.
- LOAD: next state LOAD.
- LSL/LSR/ASR with amt>0: next state SHIFT.
- Shift with amt=0, NOP, or an illegal code (101..111): next state DONE.
REQ-022 In IDLE and DONE, outputs SHALL be op=NOP, shamt=0, d_in=0.
REQ-023 The LOAD state SHALL last exactly one cycle with op=LOAD, d_in=latched data and shamt=0, then go to DONE.
REQ-024 Each SHIFT cycle SHALL drive the following outputs.
- op = latched shift code.
- shamt = min(remaining,3).
- d_in = sh_q.
- At the clock edge: remaining -= shamt.
REQ-025 SHIFT SHALL exit to DONE in the cycle whose issued shamt equals remaining.
REQ-026 Step counts SHALL be: amt 1-3 → 1 step; 4-6 → 2 steps (3 then amt-3); 7 → 3 steps (3,3,1).
REQ-027 Latency: with acceptance on edge 0 and N issue cycles, done SHALL be high during cycle N+1; sh_q then reflects the final op.
REQ-028 DONE SHALL last one cycle, then return to IDLE; a new command SHALL be acceptable on the next edge.
REQ-029 err SHALL be asserted in DONE only when the latched cmd_op is 101..111.
REQ-030 NOP with any amt SHALL complete without error and without issuing ops.
REQ-031 The remaining-count arithmetic SHALL be 3-bit unsigned and SHALL never underflow.

Reset
REQ-032 Reset SHALL force the following values immediately, including mid-command.
- state=IDLE and remaining=0.
- latched op/amt/data = 0.
- Outputs: op=NOP, shamt=0, d_in=0, busy=0, done=0, err=0, result=0, cmd_ready=1.
REQ-033 A command interrupted by reset SHALL be discarded with no done pulse.

Structure
REQ-034 Opcode constants NOP/LOAD/LSL/LSR/ASR and FSM state encodings SHALL reside in a shared package also used by the shifter next-state logic.
REQ-035 Step-size selection (min(remaining,3)) SHALL be a combinational sub-module named step_sel.
REQ-036 The block SHALL contain no shifting datapath; shifting is done solely by the downstream shifter.

Verification
REQ-037 LOAD 0xA5, then LSL amt=5: ops LSL/3, LSL/2 issued; done with result 0xA0; err=0.
REQ-038 LOAD 0x80, then ASR amt=7: shamt sequence 3,3,1; result 0xFF; done in cycle 4 after acceptance.
REQ-039 sh_q=0x3C, LSR amt=0: no shift ops; done the cycle after acceptance; result 0x3C.
REQ-040 cmd_op=111: done and err pulse together one cycle after acceptance; op stays NOP throughout.
REQ-041 cmd_valid held high with two commands back-to-back: second is accepted only on the edge after done; cmd_ready=0 throughout busy.
REQ-042 Reset asserted during the second SHIFT cycle of LSL 7: outputs return to reset values asynchronously; no done; the next command runs normally.
